// File: rtl/uart_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_pkg : shared types and defaults for the UART receive path     |
// | Rev 1.0  : initial release                                         |
// +-------------------------------------------------------------------+
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t c_SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pkt_buffer : DEPTH x 8 RAM, synchronous write, registered read     |
// | Rev 1.0    : initial release                                       |
// +-------------------------------------------------------------------+
module pkt_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_fpga,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  byte_t r_mem [DEPTH];

  // Contents are deliberately left unreset so this maps onto block/distributed RAM.
  always_ff @(posedge clk_fpga) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rx_frame_parser : SYNC/LEN framed packet parser, store-and-forward |
// | Option RX_FRAME_CHECKSUM_EN adds the trailing CHK byte check.      |
// | Rev 1.0         : initial release                                  |
// +-------------------------------------------------------------------+
module rx_frame_parser
  import uart_pkg::*;
#(
  parameter int    MAX_LEN     = 16,
  parameter int    TIMEOUT_CYC = 2_000_000,
  parameter byte_t SYNC_BYTE   = c_SYNC_BYTE_DEF
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int    c_AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int    c_GAP_W     = $clog2(TIMEOUT_CYC + 1);
  localparam byte_t c_MAX_LEN_B = byte_t'(MAX_LEN);

  rx_state_t          r_state, w_next_state;
  byte_t              r_len, r_wr_idx, r_rd_idx, r_drop_cnt;
  logic [c_GAP_W-1:0] r_gap;
  logic               r_out_valid, r_pkt_ok, r_pkt_err;
  logic               w_ok, w_err, w_timeout, w_last_in, w_last_out, w_xfer, w_wr_en;
  logic [c_AW-1:0]    w_rd_addr;
  logic [7:0]         w_rd_data;

`ifdef RX_FRAME_CHECKSUM_EN
  byte_t r_sum;
  byte_t w_sum_final;
  assign w_sum_final = r_sum + rx_data;
`endif

  assign w_timeout  = (r_state inside {ST_LEN, ST_PAYLOAD, ST_CHECK}) && !rx_valid &&
                      (r_gap == c_GAP_W'(TIMEOUT_CYC - 1));
  assign w_last_in  = (r_wr_idx == r_len - 8'd1);
  assign w_last_out = (r_rd_idx == r_len - 8'd1);
  assign w_xfer     = r_out_valid && out_ready;

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ok         = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          w_next_state = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_timeout) begin
          w_err        = 1'b1;
          w_next_state = ST_IDLE;
        end else if (rx_valid) begin
          if ((rx_data == 8'd0) || (rx_data > c_MAX_LEN_B)) begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_timeout) begin
          w_err        = 1'b1;
          w_next_state = ST_IDLE;
        end else if (rx_valid && w_last_in) begin
`ifdef RX_FRAME_CHECKSUM_EN
          w_next_state = ST_CHECK;
`else
          w_ok         = 1'b1;
          w_next_state = ST_DRAIN;
`endif
        end
      end
`ifdef RX_FRAME_CHECKSUM_EN
      ST_CHECK: begin
        if (w_timeout) begin
          w_err        = 1'b1;
          w_next_state = ST_IDLE;
        end else if (rx_valid) begin
          if (w_sum_final == 8'h00) begin
            w_ok         = 1'b1;
            w_next_state = ST_DRAIN;
          end else begin
            w_err        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (w_xfer && w_last_out) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    out_valid = r_out_valid;
    out_last  = r_out_valid && w_last_out;
    out_data  = r_out_valid ? w_rd_data : 8'h00;
    pkt_ok    = r_pkt_ok;
    pkt_err   = r_pkt_err;
    drop_cnt  = r_drop_cnt;
    w_wr_en   = (r_state == ST_PAYLOAD) && rx_valid;
    // Read one slot ahead on a transfer so the next byte is ready without a bubble.
    w_rd_addr = '0;
    if (r_state == ST_DRAIN) begin
      w_rd_addr = (w_xfer && !w_last_out) ? c_AW'(r_rd_idx + 8'd1) : c_AW'(r_rd_idx);
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_gap       <= '0;
      r_out_valid <= 1'b0;
      r_pkt_ok    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_drop_cnt  <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_pkt_ok    <= w_ok;
      r_pkt_err   <= w_err;
      // First DRAIN cycle waits for the registered RAM read of byte 0.
      r_out_valid <= (r_state == ST_DRAIN) && (w_next_state == ST_DRAIN);

      if ((r_state inside {ST_LEN, ST_PAYLOAD, ST_CHECK}) && !rx_valid) begin
        r_gap <= r_gap + c_GAP_W'(1);
      end else begin
        r_gap <= '0;
      end

      if ((r_state == ST_LEN) && (w_next_state == ST_PAYLOAD)) begin
        r_len    <= rx_data;
        r_wr_idx <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
        r_sum    <= rx_data;
`endif
      end else if (w_wr_en) begin
        r_wr_idx <= r_wr_idx + 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
        r_sum    <= r_sum + rx_data;
`endif
      end

      if (r_state != ST_DRAIN) begin
        r_rd_idx <= '0;
      end else if (w_xfer) begin
        r_rd_idx <= r_rd_idx + 8'd1;
      end

      if ((r_state == ST_DRAIN) && rx_valid && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  pkt_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (c_AW)
  ) u_pkt_buffer (
    .clk_fpga (clk_fpga),
    .wr_en    (w_wr_en),
    .wr_addr  (c_AW'(r_wr_idx)),
    .wr_data  (rx_data),
    .rd_addr  (w_rd_addr),
    .rd_data  (w_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`default_nettype none
// Testbench for rx_frame_parser: vector table plus scoreboard of expected output bytes.
module tb_rx_frame_parser;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 20;
`ifdef RX_FRAME_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk_fpga  = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, pkt_ok, pkt_err, busy;
  logic [7:0] drop_cnt;

  always #5 clk_fpga = ~clk_fpga;

  rx_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk_fpga  (clk_fpga),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  int         checks   = 0;
  int         failures = 0;
  int         ok_seen  = 0;
  int         err_seen = 0;
  logic       mon_en   = 1'b0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] len;
    logic [7:0] base;
    logic [7:0] step;
    bit         bad_chk;
    bit         exp_ok;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expected byte per accepted transfer.
  always @(negedge clk_fpga) begin : mon
    logic [8:0] e;
    if (mon_en) begin
      if (pkt_ok)  ok_seen++;
      if (pkt_err) err_seen++;
      if (pkt_ok || pkt_err) check("ok_err_exclusive", 32'(pkt_ok & pkt_err), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_last", 32'(out_last), 32'(e[8]));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_fpga); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input vec_t v);
    logic [7:0] sum;
    logic [7:0] b;
    send_byte(8'hA5);
    send_byte(v.len);
    if (v.len != 8'd0 && int'(v.len) <= MAX_LEN) begin
      sum = v.len;
      for (int i = 0; i < int'(v.len); i++) begin
        b = v.base + 8'(i) * v.step;
        if (v.exp_ok) exp_q.push_back({(i == int'(v.len) - 1), b});
        send_byte(b);
        sum = sum + b;
      end
      if (CHK_EN) send_byte(8'(8'h00 - sum) + (v.bad_chk ? 8'd1 : 8'd0));
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk_fpga); #1;
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int ok0, err0;
    ok0  = ok_seen;
    err0 = err_seen;
    send_pkt(v);
    wait_idle(name);
    repeat (3) @(posedge clk_fpga);
    #1;
    check({name, "_pkt_ok"},  32'(ok_seen - ok0),   32'(v.exp_ok));
    check({name, "_pkt_err"}, 32'(err_seen - err0), 32'(!v.exp_ok));
    check({name, "_q_empty"}, 32'(exp_q.size()),    32'd0);
  endtask

  initial begin : main
    int         ok0, err0, n;
    logic [7:0] d0;

    // CHK byte is derived so LEN + payload + CHK sums to zero; bad_chk adds one.
    vecs[0] = '{len: 8'd3,  base: 8'h11, step: 8'h11, bad_chk: 1'b0, exp_ok: 1'b1};
    vecs[1] = '{len: 8'd1,  base: 8'h5A, step: 8'h00, bad_chk: 1'b0, exp_ok: 1'b1};
    vecs[2] = '{len: 8'd16, base: 8'h30, step: 8'h01, bad_chk: 1'b0, exp_ok: 1'b1};
    vecs[3] = '{len: 8'd0,  base: 8'h00, step: 8'h00, bad_chk: 1'b0, exp_ok: 1'b0};
    vecs[4] = '{len: 8'h11, base: 8'h00, step: 8'h00, bad_chk: 1'b0, exp_ok: 1'b0};
    vecs[5] = '{len: 8'hFF, base: 8'h00, step: 8'h00, bad_chk: 1'b0, exp_ok: 1'b0};
    vecs[6] = '{len: 8'd2,  base: 8'hA5, step: 8'h00, bad_chk: 1'b0, exp_ok: 1'b1};
    vecs[7] = '{len: 8'd3,  base: 8'h11, step: 8'h11, bad_chk: 1'b1, exp_ok: !CHK_EN};

    repeat (3) @(posedge clk_fpga);
    #1;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_pkt_ok",    32'(pkt_ok),    32'd0);
    check("rst_pkt_err",   32'(pkt_err),   32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_fpga); #1;

    // Non-sync bytes in IDLE are ignored.
    send_byte(8'h3C);
    send_byte(8'h00);
    check("idle_ignore_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Gap timeout mid-payload.
    err0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h44);
    repeat (TIMEOUT_CYC - 1) @(posedge clk_fpga);
    #1;
    check("to_busy_before", 32'(busy), 32'd1);
    @(posedge clk_fpga); #1;
    check("to_busy_after", 32'(busy),    32'd0);
    check("to_pulse",      32'(pkt_err), 32'd1);
    repeat (TIMEOUT_CYC + 5) @(posedge clk_fpga);
    #1;
    check("to_err_once", 32'(err_seen - err0), 32'd1);
    check("to_idle",     32'(busy),            32'd0);

    // Backpressure in DRAIN with bytes arriving (one a SYNC_BYTE) that must be dropped.
    ok0       = ok_seen;
    out_ready = 1'b0;
    send_pkt(vecs[0]);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk_fpga); #1;
      n++;
    end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    d0 = out_data;
    check("bp_first_byte", 32'(d0), 32'h11);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_fpga); #1;
      rx_valid = (i == 2) || (i == 5);
      rx_data  = (i == 5) ? 8'hA5 : 8'h77;
      #3;
      check("bp_data_hold",  32'(out_data),  32'(d0));
      check("bp_valid_hold", 32'(out_valid), 32'd1);
    end
    @(posedge clk_fpga); #1;
    rx_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle("bp");
    repeat (2) @(posedge clk_fpga);
    #1;
    check("bp_drop_cnt", 32'(drop_cnt),         32'd2);
    check("bp_pkt_ok",   32'(ok_seen - ok0),    32'd1);
    check("bp_q_empty",  32'(exp_q.size()),     32'd0);

    // Reset in the middle of a payload abandons it silently.
    err0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    @(posedge clk_fpga); #1;
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_drop_cnt",  32'(drop_cnt),  32'd0);
    @(posedge clk_fpga); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_fpga);
    #1;
    check("mid_rst_no_err", 32'(err_seen - err0), 32'd0);
    run_vec(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
